// File: rtl/cpu_params.sv
// Shared CPU configuration for the retirement register file slice.
// Holds the register file geometry, commit/restore widths and the restore FSM state type.
package cpu_params;

  localparam int unsigned ARF_DEPTH     = 32;
  localparam int unsigned PRF_DEPTH     = 64;
  localparam int unsigned ARF_IDX       = $clog2(ARF_DEPTH);
  localparam int unsigned PRF_IDX       = $clog2(PRF_DEPTH);
  localparam int unsigned COMMIT_WIDTH  = 2;
  localparam int unsigned RESTORE_WIDTH = 4;

  localparam int unsigned RESTORE_BEATS = ARF_DEPTH / RESTORE_WIDTH;
  localparam int unsigned BEAT_IDX      = (RESTORE_BEATS > 1) ? $clog2(RESTORE_BEATS) : 1;

  typedef enum logic [1:0] {
    RRF_IDLE,
    RRF_RESTORE,
    RRF_DONE
  } rrf_restore_state_t;

endpackage

// File: rtl/rrf_multi_commit_if.sv
// Bus between the ROB/free list/RAT side (master) and the retirement register file (slave).
//   commit_valid/commit_rd_arch/commit_rd_phy : retirement lanes from the ROB
//   free_valid/free_idx                       : stale physical indices to the free list
//   restore_req/restore_busy/restore_done     : flush restore control
//   rat_wr_valid/rat_wr_base/rat_wr_phy       : restore beats to the RAT
//   perf_free_cnt                             : freed-register counter (0 unless enabled)
interface rrf_multi_commit_if;
  import cpu_params::*;

  logic [COMMIT_WIDTH-1:0]                commit_valid;
  logic [COMMIT_WIDTH-1:0][ARF_IDX-1:0]   commit_rd_arch;
  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0]   commit_rd_phy;
  logic [COMMIT_WIDTH-1:0]                free_valid;
  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0]   free_idx;
  logic                                   restore_req;
  logic                                   restore_busy;
  logic                                   rat_wr_valid;
  logic [ARF_IDX-1:0]                     rat_wr_base;
  logic [RESTORE_WIDTH-1:0][PRF_IDX-1:0]  rat_wr_phy;
  logic                                   restore_done;
  logic [31:0]                            perf_free_cnt;

  modport master (
    output commit_valid, commit_rd_arch, commit_rd_phy, restore_req,
    input  free_valid, free_idx, restore_busy, rat_wr_valid, rat_wr_base, rat_wr_phy,
           restore_done, perf_free_cnt
  );

  modport slave (
    input  commit_valid, commit_rd_arch, commit_rd_phy, restore_req,
    output free_valid, free_idx, restore_busy, rat_wr_valid, rat_wr_base, rat_wr_phy,
           restore_done, perf_free_cnt
  );

endinterface

// File: rtl/rrf_commit_resolve.sv
// Combinational intra-bundle chaining for retirement lanes.
//   valid/rd_arch/rd_phy : commit lanes
//   mem_rd               : committed mapping of each lane's rd_arch
//   free_valid/free_idx  : stale index per lane (0 for inactive lanes)
//   wr_en                : lane may write the map (masked if a later lane hits the same rd)
module rrf_commit_resolve
  import cpu_params::*;
(
  input  logic [COMMIT_WIDTH-1:0]              valid,
  input  logic [COMMIT_WIDTH-1:0][ARF_IDX-1:0] rd_arch,
  input  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0] rd_phy,
  input  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0] mem_rd,
  output logic [COMMIT_WIDTH-1:0]              free_valid,
  output logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0] free_idx,
  output logic [COMMIT_WIDTH-1:0]              wr_en
);

  logic [COMMIT_WIDTH-1:0] active;

  always_comb begin
    active   = '0;
    free_idx = '0;
    wr_en    = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      active[i] = valid[i] && (rd_arch[i] != '0);
    end
    free_valid = active;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (active[i]) begin
        free_idx[i] = mem_rd[i];
        // Ascending scan: the highest earlier lane with the same rd wins.
        for (int j = 0; j < i; j++) begin
          if (active[j] && (rd_arch[j] == rd_arch[i])) free_idx[i] = rd_phy[j];
        end
        wr_en[i] = 1'b1;
        for (int j = i + 1; j < COMMIT_WIDTH; j++) begin
          if (active[j] && (rd_arch[j] == rd_arch[i])) wr_en[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rrf_multi_commit.sv
// Retirement register file: committed arch-to-phys map with multi-lane retirement and a
// flush restore walk that streams the map to the RAT RESTORE_WIDTH entries per beat.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rrf_multi_commit_if slave (commit, free, restore and RAT write signals)
// Optional feature macro RRF_FREE_CNT_EN: enables the 32-bit perf_free_cnt counter;
// otherwise perf_free_cnt is tied to 0.
module rrf_multi_commit
  import cpu_params::*;
(
  input logic              clk,
  input logic              rst,
  rrf_multi_commit_if.slave bus
);

  logic [PRF_IDX-1:0]                   mem [ARF_DEPTH];
  logic [COMMIT_WIDTH-1:0][PRF_IDX-1:0] mem_rd;
  logic [COMMIT_WIDTH-1:0]              wr_en;
  rrf_restore_state_t                   state;
  logic [BEAT_IDX-1:0]                  ptr;

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) mem_rd[i] = mem[bus.commit_rd_arch[i]];
  end

  rrf_commit_resolve u_resolve (
    .valid      (bus.commit_valid),
    .rd_arch    (bus.commit_rd_arch),
    .rd_phy     (bus.commit_rd_phy),
    .mem_rd     (mem_rd),
    .free_valid (bus.free_valid),
    .free_idx   (bus.free_idx),
    .wr_en      (wr_en)
  );

  // Losing lanes are already masked, so at most one lane writes each entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARF_DEPTH; i++) mem[i] <= PRF_IDX'(i);
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
        if (wr_en[i]) mem[bus.commit_rd_arch[i]] <= bus.commit_rd_phy[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RRF_IDLE;
      ptr               <= '0;
      bus.restore_busy  <= 1'b0;
      bus.rat_wr_valid  <= 1'b0;
      bus.rat_wr_base   <= '0;
      bus.restore_done  <= 1'b0;
    end else begin
      unique case (state)
        RRF_IDLE: begin
          bus.restore_done <= 1'b0;
          if (bus.restore_req) begin
            state            <= RRF_RESTORE;
            ptr              <= '0;
            bus.restore_busy <= 1'b1;
            bus.rat_wr_valid <= 1'b1;
            bus.rat_wr_base  <= '0;
          end
        end
        RRF_RESTORE: begin
          if (ptr == BEAT_IDX'(RESTORE_BEATS - 1)) begin
            state            <= RRF_DONE;
            bus.rat_wr_valid <= 1'b0;
            bus.rat_wr_base  <= '0;
            bus.restore_done <= 1'b1;
          end else begin
            ptr             <= ptr + 1'b1;
            bus.rat_wr_base <= ARF_IDX'((32'(ptr) + 32'd1) * RESTORE_WIDTH);
          end
        end
        RRF_DONE: begin
          state            <= RRF_IDLE;
          bus.restore_done <= 1'b0;
          bus.restore_busy <= 1'b0;
        end
        default: state <= RRF_IDLE;
      endcase
    end
  end

  // Beat data reads the map live so commits landing mid-walk show in later beats.
  always_comb begin
    bus.rat_wr_phy = '0;
    if (bus.rat_wr_valid) begin
      for (int k = 0; k < RESTORE_WIDTH; k++) begin
        bus.rat_wr_phy[k] = mem[bus.rat_wr_base + ARF_IDX'(k)];
      end
    end
  end

`ifdef RRF_FREE_CNT_EN
  logic [31:0] free_inc;
  logic [31:0] free_cnt;

  always_comb begin
    free_inc = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) free_inc = free_inc + 32'(bus.free_valid[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) free_cnt <= '0;
    else     free_cnt <= free_cnt + free_inc;
  end

  assign bus.perf_free_cnt = free_cnt;
`else
  assign bus.perf_free_cnt = '0;
`endif

  // The ROB never retires during a restore walk.
  commit_while_busy : assert property (
    @(posedge clk) disable iff (rst) bus.restore_busy |-> (bus.commit_valid == '0)
  );

endmodule

// File: tb/tb_rrf_multi_commit.sv
module tb_rrf_multi_commit;
  import cpu_params::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rrf_multi_commit_if bus ();

  rrf_multi_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit;
    bus.commit_valid   = '0;
    bus.commit_rd_arch = '0;
    bus.commit_rd_phy  = '0;
  endtask

  task automatic set_lane(input int lane, input int arch, input int phy);
    bus.commit_valid[lane]   = 1'b1;
    bus.commit_rd_arch[lane] = ARF_IDX'(arch);
    bus.commit_rd_phy[lane]  = PRF_IDX'(phy);
  endtask

  initial begin
    int beats;
    int busy_cnt;
    bit got_done;

    n_checks = 0;
    n_fail   = 0;
    clear_commit();
    bus.restore_req = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_eq("rst_busy", 32'(bus.restore_busy), 32'd0);
    check_eq("rst_valid", 32'(bus.rat_wr_valid), 32'd0);
    check_eq("rst_done", 32'(bus.restore_done), 32'd0);
    check_eq("rst_free_valid", 32'(bus.free_valid), 32'd0);
    check_eq("rst_perf", bus.perf_free_cnt, 32'd0);
    check_eq("rst_mem5", 32'(dut.mem[5]), 32'd5);

    // Single lane commit x5 -> p40
    set_lane(0, 5, 40);
    #1;
    check_eq("c1_free_valid", 32'(bus.free_valid), 32'd1);
    check_eq("c1_free_idx0", 32'(bus.free_idx[0]), 32'd5);
    step();
    clear_commit();
    check_eq("c1_mem5", 32'(dut.mem[5]), 32'd40);

    // Same-rd chaining: x7 -> p41 then x7 -> p42
    set_lane(0, 7, 41);
    set_lane(1, 7, 42);
    #1;
    check_eq("c2_free_valid", 32'(bus.free_valid), 32'd3);
    check_eq("c2_free_idx0", 32'(bus.free_idx[0]), 32'd7);
    check_eq("c2_free_idx1", 32'(bus.free_idx[1]), 32'd41);
    step();
    clear_commit();
    check_eq("c2_mem7", 32'(dut.mem[7]), 32'd42);

    // x0 on lane1 is dropped
    set_lane(1, 0, 50);
    #1;
    check_eq("c3_free_valid", 32'(bus.free_valid), 32'd0);
    check_eq("c3_free_idx1", 32'(bus.free_idx[1]), 32'd0);
    check_eq("c3_free_idx0", 32'(bus.free_idx[0]), 32'd0);
    step();
    clear_commit();
    check_eq("c3_mem0", 32'(dut.mem[0]), 32'd0);

    // x9 -> p44, then a full restore walk
    set_lane(0, 9, 44);
    step();
    clear_commit();
    bus.restore_req = 1'b1;
    step();
    bus.restore_req = 1'b0;
    busy_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      check_eq($sformatf("r1_valid_%0d", b), 32'(bus.rat_wr_valid), 32'd1);
      check_eq($sformatf("r1_base_%0d", b), 32'(bus.rat_wr_base), 32'(b * 4));
      if (bus.restore_busy) busy_cnt++;
      if (b == 0) check_eq("r1_b0_phy2", 32'(bus.rat_wr_phy[2]), 32'd2);
      if (b == 1) begin
        check_eq("r1_b1_phy1", 32'(bus.rat_wr_phy[1]), 32'd40);
        check_eq("r1_b1_phy3", 32'(bus.rat_wr_phy[3]), 32'd42);
      end
      if (b == 2) check_eq("r1_b2_phy1", 32'(bus.rat_wr_phy[1]), 32'd44);
      check_eq($sformatf("r1_nodone_%0d", b), 32'(bus.restore_done), 32'd0);
      step();
    end
    check_eq("r1_done", 32'(bus.restore_done), 32'd1);
    check_eq("r1_done_valid", 32'(bus.rat_wr_valid), 32'd0);
    check_eq("r1_done_phy", 32'(bus.rat_wr_phy), 32'd0);
    if (bus.restore_busy) busy_cnt++;
    step();
    check_eq("r1_busy_cycles", 32'(busy_cnt), 32'd9);
    check_eq("r1_idle_busy", 32'(bus.restore_busy), 32'd0);
    check_eq("r1_idle_done", 32'(bus.restore_done), 32'd0);

    // Commit x3 -> p60 alongside restore_req; second request mid-walk is ignored
    set_lane(0, 3, 60);
    bus.restore_req = 1'b1;
    step();
    clear_commit();
    bus.restore_req = 1'b0;
    beats    = 0;
    got_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rat_wr_valid) beats++;
      if (c == 0) check_eq("r2_b0_phy3", 32'(bus.rat_wr_phy[3]), 32'd60);
      if (bus.restore_done) begin
        got_done = 1'b1;
        break;
      end
      bus.restore_req = (c == 3);
      step();
    end
    bus.restore_req = 1'b0;
    check_eq("r2_done_seen", 32'(got_done), 32'd1);
    check_eq("r2_beats", 32'(beats), 32'd8);
    step();
    check_eq("r2_idle_busy", 32'(bus.restore_busy), 32'd0);
    step();
    check_eq("r2_no_restart", 32'(bus.restore_busy), 32'd0);

    // Reset during beat 3
    bus.restore_req = 1'b1;
    step();
    bus.restore_req = 1'b0;
    step();
    step();
    step();
    check_eq("r3_beat3_base", 32'(bus.rat_wr_base), 32'd12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("r3_busy", 32'(bus.restore_busy), 32'd0);
    check_eq("r3_valid", 32'(bus.rat_wr_valid), 32'd0);
    check_eq("r3_phy", 32'(bus.rat_wr_phy), 32'd0);
    check_eq("r3_done", 32'(bus.restore_done), 32'd0);
    check_eq("r3_mem7", 32'(dut.mem[7]), 32'd7);
    step();
    check_eq("r3_done_late", 32'(bus.restore_done), 32'd0);
    set_lane(0, 4, 10);
    set_lane(1, 5, 11);
    #1;
    check_eq("r3_free_idx0", 32'(bus.free_idx[0]), 32'd4);
    check_eq("r3_free_idx1", 32'(bus.free_idx[1]), 32'd5);
    step();
    clear_commit();

    // Free counter: three two-lane commits after reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("cnt_rst", bus.perf_free_cnt, 32'd0);
    for (int n = 0; n < 3; n++) begin
      set_lane(0, 10 + 2 * n, 33 + 2 * n);
      set_lane(1, 11 + 2 * n, 34 + 2 * n);
      step();
    end
    clear_commit();
`ifdef RRF_FREE_CNT_EN
    check_eq("cnt_value", bus.perf_free_cnt, 32'd6);
`else
    check_eq("cnt_value", bus.perf_free_cnt, 32'd0);
`endif
    check_eq("cnt_mem15", 32'(dut.mem[15]), 32'd38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
